// File: rtl/dsn_pkg.sv
// Shared definitions for the DS2401-style 1-Wire responder.
// Holds the default timing constants (in 40 MHz clock cycles), the single
// supported command code, the responder state encoding and the low-pulse
// class codes produced by the pulse classifier.
package dsn_pkg;

  localparam int unsigned MXCNT        = 16;     // timing counter width
  localparam int unsigned T_GLITCH     = 4;      // 100 ns
  localparam int unsigned T_BIT0_MIN   = 600;    // 15 us
  localparam int unsigned T_RST_MIN    = 19200;  // 480 us
  localparam int unsigned T_PD_WAIT    = 1200;   // 30 us
  localparam int unsigned T_PD_LEN     = 4800;   // 120 us
  localparam int unsigned T_TX_HOLD    = 1200;   // 30 us

  localparam logic [7:0]  CMD_READ_ROM = 8'h33;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRES_WAIT = 3'd1,
    PRES_DRV  = 3'd2,
    RX_CMD    = 3'd3,
    TX_ROM    = 3'd4,
    HALT      = 3'd5
  } dsn_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BIT1 = 2'd1,
    BIT0 = 2'd2,
    RST  = 2'd3
  } pulse_class_t;

endpackage

// File: rtl/dsn_slave_if.sv
// Signal bundle between the DSN responder and its surroundings.
//   enable    : 1 = respond on the line, 0 = ignore line, dsn_out held 1
//   dsn_in    : sensed (wired-AND) line level, asynchronous
//   dsn_out   : 0 = pull line low, 1 = release (registered)
//   rom_code  : 64-bit ROM image, sampled when Read ROM is accepted
//   busy      : transaction in progress
//   cmd_byte  : last received command byte
//   cmd_valid : strobe, 8 command bits received
//   cmd_err   : strobe, command was not Read ROM
//   tx_done   : strobe, 64th ROM bit slot finished
interface dsn_slave_if;
  logic        enable;
  logic        dsn_in;
  logic        dsn_out;
  logic [63:0] rom_code;
  logic        busy;
  logic [7:0]  cmd_byte;
  logic        cmd_valid;
  logic        cmd_err;
  logic        tx_done;

  modport slave (
    input  enable, dsn_in, rom_code,
    output dsn_out, busy, cmd_byte, cmd_valid, cmd_err, tx_done
  );

  modport master (
    output enable, dsn_in, rom_code,
    input  dsn_out, busy, cmd_byte, cmd_valid, cmd_err, tx_done
  );
endinterface

// File: rtl/dsn_low_meas.sv
// Line sampler and low-pulse classifier.
//   clock, reset : clock and synchronous active-high reset
//   dsn_in       : asynchronous line level
//   fall         : line_s falling edge (master slot start)
//   pulse_vld    : rising edge ending a low pulse of at least T_GLITCH cycles
//   pulse_class  : BIT1 / BIT0 / RST classification of that pulse
module dsn_low_meas
  import dsn_pkg::*;
#(
  parameter int unsigned MXCNT      = dsn_pkg::MXCNT,
  parameter int unsigned T_GLITCH   = dsn_pkg::T_GLITCH,
  parameter int unsigned T_BIT0_MIN = dsn_pkg::T_BIT0_MIN,
  parameter int unsigned T_RST_MIN  = dsn_pkg::T_RST_MIN
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         dsn_in,
  output logic         fall,
  output logic         pulse_vld,
  output pulse_class_t pulse_class
);

  logic             sync_q1;
  logic             line_s;
  logic             line_d;
  logic             rise;
  logic [MXCNT-1:0] low_cnt;
  logic [31:0]      low_len;

  // Synchronizer and edge flops idle high so leaving reset never fakes an edge.
  // The counter loads 1 on the falling edge so that at the rising edge it holds
  // exactly the number of cycles the line was low.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      line_s  <= 1'b1;
      line_d  <= 1'b1;
      low_cnt <= '0;
    end else begin
      sync_q1 <= dsn_in;
      line_s  <= sync_q1;
      line_d  <= line_s;
      if (fall)
        low_cnt <= {{(MXCNT-1){1'b0}}, 1'b1};
      else if (!line_s && (low_cnt != '1))
        low_cnt <= low_cnt + 1'b1;
    end
  end

  assign fall    = line_d & ~line_s;
  assign rise    = ~line_d & line_s;
  assign low_len = 32'(low_cnt);

  always_comb begin
    pulse_class = NONE;
    if (low_len >= T_RST_MIN)
      pulse_class = RST;
    else if (low_len >= T_BIT0_MIN)
      pulse_class = BIT0;
    else if (low_len >= T_GLITCH)
      pulse_class = BIT1;
  end

  assign pulse_vld = rise && (pulse_class != NONE);

endmodule

// File: rtl/dsn_slave.sv
// DS2401-style Digital Serial Number responder (1-Wire slave).
// Detects the master reset pulse, answers with a presence pulse, receives a
// command byte LSB first and, for Read ROM, shifts out the 64-bit ROM code.
//   clock        : 40 MHz clock
//   global_reset : synchronous active-high reset
//   dsn          : line, control and status bundle (dsn_slave_if.slave)
module dsn_slave
  import dsn_pkg::*;
#(
  parameter int unsigned MXCNT      = dsn_pkg::MXCNT,
  parameter int unsigned T_GLITCH   = dsn_pkg::T_GLITCH,
  parameter int unsigned T_BIT0_MIN = dsn_pkg::T_BIT0_MIN,
  parameter int unsigned T_RST_MIN  = dsn_pkg::T_RST_MIN,
  parameter int unsigned T_PD_WAIT  = dsn_pkg::T_PD_WAIT,
  parameter int unsigned T_PD_LEN   = dsn_pkg::T_PD_LEN,
  parameter int unsigned T_TX_HOLD  = dsn_pkg::T_TX_HOLD
) (
  input  logic        clock,
  input  logic        global_reset,
  dsn_slave_if.slave  dsn
);

  logic             meas_rst;
  logic             fall;
  logic             pulse_vld;
  pulse_class_t     pulse_class;
  logic             is_rst;
  logic             is_bit;
  logic [7:0]       cmd_next;

  dsn_state_t       state;
  logic [MXCNT-1:0] tmr;
  logic [6:0]       bit_cnt;
  logic [63:0]      rom_sr;
  logic             own_low;

  assign meas_rst = global_reset | ~dsn.enable;

  dsn_low_meas #(
    .MXCNT      (MXCNT),
    .T_GLITCH   (T_GLITCH),
    .T_BIT0_MIN (T_BIT0_MIN),
    .T_RST_MIN  (T_RST_MIN)
  ) u_low_meas (
    .clock       (clock),
    .reset       (meas_rst),
    .dsn_in      (dsn.dsn_in),
    .fall        (fall),
    .pulse_vld   (pulse_vld),
    .pulse_class (pulse_class)
  );

  assign is_rst   = pulse_vld && (pulse_class == RST);
  assign is_bit   = pulse_vld && (pulse_class != RST);
  assign cmd_next = {pulse_class == BIT1, dsn.cmd_byte[7:1]};

  // own_low marks a low pulse we drove ourselves (presence or 0-bit hold).
  // The line is wired-AND, so its rising edge is seen by the classifier; it is
  // dropped so the presence pulse is not taken as the first command bit.
  always_ff @(posedge clock) begin
    if (global_reset || !dsn.enable) begin
      state         <= IDLE;
      dsn.dsn_out   <= 1'b1;
      dsn.busy      <= 1'b0;
      dsn.cmd_valid <= 1'b0;
      dsn.cmd_err   <= 1'b0;
      dsn.tx_done   <= 1'b0;
      tmr           <= '0;
      bit_cnt       <= '0;
      rom_sr        <= '0;
      own_low       <= 1'b0;
      if (global_reset)
        dsn.cmd_byte <= '0;
    end else begin
      dsn.cmd_valid <= 1'b0;
      dsn.cmd_err   <= 1'b0;
      dsn.tx_done   <= 1'b0;
      if (pulse_vld)
        own_low <= 1'b0;

      if (is_rst) begin
        state       <= PRES_WAIT;
        tmr         <= '0;
        bit_cnt     <= '0;
        dsn.dsn_out <= 1'b1;
        dsn.busy    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            dsn.dsn_out <= 1'b1;
          end

          PRES_WAIT: begin
            if (32'(tmr) == T_PD_WAIT - 1) begin
              tmr         <= '0;
              dsn.dsn_out <= 1'b0;
              own_low     <= 1'b1;
              state       <= PRES_DRV;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end

          PRES_DRV: begin
            if (32'(tmr) == T_PD_LEN - 1) begin
              tmr         <= '0;
              bit_cnt     <= '0;
              dsn.dsn_out <= 1'b1;
              state       <= RX_CMD;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end

          RX_CMD: begin
            if (is_bit && !own_low) begin
              dsn.cmd_byte <= cmd_next;
              if (bit_cnt == 7'd7) begin
                bit_cnt       <= '0;
                dsn.cmd_valid <= 1'b1;
                if (cmd_next == CMD_READ_ROM) begin
                  rom_sr <= dsn.rom_code;
                  state  <= TX_ROM;
                end else begin
                  dsn.cmd_err <= 1'b1;
                  dsn.busy    <= 1'b0;
                  state       <= HALT;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end

          // A running 0-bit hold takes priority: the line is low anyway, so a
          // second slot start inside the hold is ignored. tx_done waits until
          // the last hold has been released.
          TX_ROM: begin
            if (!dsn.dsn_out) begin
              if (32'(tmr) == T_TX_HOLD - 1) begin
                tmr         <= '0;
                dsn.dsn_out <= 1'b1;
              end else begin
                tmr <= tmr + 1'b1;
              end
            end else if (bit_cnt == 7'd64) begin
              dsn.tx_done <= 1'b1;
              dsn.busy    <= 1'b0;
              state       <= HALT;
            end else if (fall) begin
              if (!rom_sr[0]) begin
                dsn.dsn_out <= 1'b0;
                own_low     <= 1'b1;
                tmr         <= '0;
              end
              rom_sr  <= {1'b0, rom_sr[63:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          HALT: begin
            dsn.dsn_out <= 1'b1;
            dsn.busy    <= 1'b0;
          end

          default: begin
            state       <= IDLE;
            dsn.dsn_out <= 1'b1;
            dsn.busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsn_slave.sv
// Self-checking bench for dsn_slave acting as a 1-Wire master on a wired-AND
// line. Timing parameters are scaled down so the run stays short.
module tb_dsn_slave;
  import dsn_pkg::*;

  localparam int unsigned P_MXCNT  = 10;   // saturates at 1023
  localparam int unsigned P_GLITCH = 4;
  localparam int unsigned P_BIT0   = 60;
  localparam int unsigned P_RST    = 480;
  localparam int unsigned P_PDW    = 120;
  localparam int unsigned P_PDL    = 240;
  localparam int unsigned P_HOLD   = 120;

  localparam int unsigned RD_SLOT   = 200;
  localparam int unsigned RD_LOW    = 6;
  localparam int unsigned RD_SAMPLE = 30;

  typedef struct packed {
    logic [7:0] cmd;
    logic       err;
  } cmd_exp_t;

  logic        clock        = 1'b0;
  logic        global_reset = 1'b1;
  logic        m_out        = 1'b1;
  int unsigned n_assert     = 0;
  int unsigned n_fail       = 0;
  int unsigned slot_cnt     = 0;

  cmd_exp_t    exp_cmd[$];
  int unsigned exp_done[$];
  logic        exp_bit[$];
  cmd_exp_t    ce;

  dsn_slave_if bus();
  assign bus.dsn_in = m_out & bus.dsn_out;

  always #5 clock = ~clock;

  dsn_slave #(
    .MXCNT      (P_MXCNT),
    .T_GLITCH   (P_GLITCH),
    .T_BIT0_MIN (P_BIT0),
    .T_RST_MIN  (P_RST),
    .T_PD_WAIT  (P_PDW),
    .T_PD_LEN   (P_PDL),
    .T_TX_HOLD  (P_HOLD)
  ) dut (
    .clock        (clock),
    .global_reset (global_reset),
    .dsn          (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic raw_pulse(input int unsigned len, input int unsigned gap);
    m_out = 1'b0;
    tick(len);
    m_out = 1'b1;
    tick(gap);
  endtask

  task automatic write_byte(input logic [7:0] v, input logic err);
    exp_cmd.push_back('{cmd: v, err: err});
    slot_cnt = 0;
    for (int i = 0; i < 8; i++)
      raw_pulse(v[i] ? 6 : 100, 100);
  endtask

  // Reset pulse, then measure presence delay (from line release) and width.
  task automatic do_reset(input int unsigned len, input string tag);
    int unsigned d = 0;
    int unsigned w = 0;
    m_out = 1'b0;
    tick(len);
    m_out = 1'b1;
    while (bus.dsn_out && d < 4 * P_PDW) begin
      tick(1);
      d++;
    end
    check({tag, "_pd_delay"}, d, P_PDW + 3);
    check({tag, "_busy"}, bus.busy, 1'b1);
    while (!bus.dsn_out && w < 4 * P_PDL) begin
      tick(1);
      w++;
    end
    check({tag, "_pd_len"}, w, P_PDL);
    tick(20);
  endtask

  task automatic read_slot(input logic eb, input string tag);
    int unsigned lowc = 0;
    logic        expb;
    exp_bit.push_back(eb);
    slot_cnt++;
    expb  = eb;
    m_out = 1'b0;
    for (int k = 1; k <= int'(RD_SLOT); k++) begin
      tick(1);
      if (k == int'(RD_LOW)) m_out = 1'b1;
      if (!bus.dsn_out) lowc++;
      if (k == int'(RD_SAMPLE)) begin
        expb = exp_bit.pop_front();
        check({tag, "_bit"}, bus.dsn_in, expb);
      end
    end
    check({tag, "_hold"}, lowc, expb ? 0 : P_HOLD);
  endtask

  always @(negedge clock) begin
    if (!global_reset) begin
      if (bus.cmd_valid) begin
        check("cmd_expected", exp_cmd.size() != 0, 1'b1);
        if (exp_cmd.size() != 0) begin
          ce = exp_cmd.pop_front();
          check("cmd_byte", bus.cmd_byte, ce.cmd);
          check("cmd_err", bus.cmd_err, ce.err);
        end
      end else if (bus.cmd_err) begin
        check("cmd_err_stray", bus.cmd_valid, 1'b1);
      end
      if (bus.tx_done) begin
        check("done_expected", exp_done.size() != 0, 1'b1);
        if (exp_done.size() != 0)
          check("tx_done_slot", slot_cnt, exp_done.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rom;
    bus.enable   = 1'b1;
    bus.rom_code = '0;
    tick(5);
    check("rst_dsn_out", bus.dsn_out, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_cmd_byte", bus.cmd_byte, 8'h00);
    check("rst_strobes", {bus.cmd_valid, bus.cmd_err, bus.tx_done}, 3'b000);
    global_reset = 1'b0;
    tick(5);
    check("idle_busy", bus.busy, 1'b0);

    // Long reset (saturates the counter), presence timing.
    do_reset(2000, "t1");

    // Read ROM command, then 64 read slots; rom_code changed after accept.
    rom          = 64'hA5_000000123456_01;
    bus.rom_code = rom;
    write_byte(CMD_READ_ROM, 1'b0);
    check("t2_busy", bus.busy, 1'b1);
    bus.rom_code = ~rom;
    exp_done.push_back(64);
    for (int i = 0; i < 64; i++) read_slot(rom[i], "t3");
    check("t3_halt_busy", bus.busy, 1'b0);

    // Unsupported command: error strobe, halted, line stays released.
    do_reset(600, "t4");
    write_byte(8'hF0, 1'b1);
    check("t4_busy", bus.busy, 1'b0);
    for (int i = 0; i < 16; i++) read_slot(1'b1, "t4_halt");

    // Reset injected at bit 20 of a ROM read, then a full fresh read.
    rom          = 64'h0123_4567_89AB_CDEF;
    bus.rom_code = rom;
    do_reset(600, "t5a");
    write_byte(CMD_READ_ROM, 1'b0);
    for (int i = 0; i < 20; i++) read_slot(rom[i], "t5a");
    do_reset(600, "t5b");
    rom          = 64'h3C96_0F0F_F0F0_1234;
    bus.rom_code = rom;
    write_byte(CMD_READ_ROM, 1'b0);
    exp_done.push_back(64);
    for (int i = 0; i < 64; i++) read_slot(rom[i], "t5b");

    // Classification boundaries: 480 = reset, 479 = bit0, 60 = bit0,
    // 59 = bit1, 2 and 3 = glitch. Bits LSB first 0,1,0,1,1,0,1,1 = 8'hDA.
    do_reset(P_RST, "t6_rst");
    exp_cmd.push_back('{cmd: 8'hDA, err: 1'b1});
    raw_pulse(2, 100);
    raw_pulse(P_BIT0, 100);
    raw_pulse(P_BIT0 - 1, 100);
    raw_pulse(P_RST - 1, 100);
    raw_pulse(3, 100);
    raw_pulse(6, 100);
    raw_pulse(6, 100);
    raw_pulse(100, 100);
    raw_pulse(6, 100);
    raw_pulse(6, 100);
    check("t6_busy", bus.busy, 1'b0);

    // enable=0 during presence drive: released, idle, cmd_byte kept.
    raw_pulse(600, P_PDW + 13);
    check("t7_drv", bus.dsn_out, 1'b0);
    bus.enable = 1'b0;
    tick(2);
    check("t7_dsn_out", bus.dsn_out, 1'b1);
    check("t7_busy", bus.busy, 1'b0);
    check("t7_cmd_hold", bus.cmd_byte, 8'hDA);
    bus.enable = 1'b1;
    tick(P_PDL + 50);
    check("t7_idle_out", bus.dsn_out, 1'b1);

    check("cmd_q_empty", exp_cmd.size(), 0);
    check("done_q_empty", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
